// File: rtl/remap_spi_master.sv
// SPI mode-0 master for one 16-bit {rw, addr[6:0], data[7:0]} frame per command.
// The 8 MISO bits sampled during the data phase are returned on rsp_rdata.
module remap_spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned GAP      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] ONE        = CW'(1'b1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    bit_r, bit_s;
  logic          high_r, high_s;
  logic [14:0]   frame_r, frame_s;
  logic [7:0]    shreg_r, shreg_s;
  logic          cs_n_r, cs_n_s;
  logic          sclk_r, sclk_s;
  logic          mosi_r, mosi_s;
  logic          ready_r, ready_s;
  logic          busy_r, busy_s;
  logic          rsp_valid_r, rsp_valid_s;
  logic [7:0]    rdata_r, rdata_s;
  logic [15:0]   cmd_frame_s;

  // Reads never drive write data onto the bus.
  assign cmd_frame_s = {cmd_rw, cmd_addr, (cmd_rw ? 8'h00 : cmd_wdata)};

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_s       = bit_r;
    high_s      = high_r;
    frame_s     = frame_r;
    shreg_s     = shreg_r;
    cs_n_s      = cs_n_r;
    sclk_s      = sclk_r;
    mosi_s      = mosi_r;
    ready_s     = ready_r;
    busy_s      = busy_r;
    rsp_valid_s = 1'b0;
    rdata_s     = rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && ready_r) begin
          state_s = ST_SETUP;
          cnt_s   = '0;
          frame_s = cmd_frame_s[14:0];
          mosi_s  = cmd_frame_s[15];
          cs_n_s  = 1'b0;
          ready_s = 1'b0;
          busy_s  = 1'b1;
        end else begin
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_s = ST_SHIFT;
          cnt_s   = '0;
          bit_s   = 4'd0;
          high_s  = 1'b1;
          sclk_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + ONE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r != DIV_LAST) begin
          cnt_s = cnt_r + ONE;
        end else if (high_r) begin
          // End of a high half: sample MISO, drop SCLK, present the next bit.
          cnt_s   = '0;
          shreg_s = {shreg_r[6:0], spi_miso};
          high_s  = 1'b0;
          sclk_s  = 1'b0;
          if (bit_r != 4'd15) begin
            mosi_s = frame_r[4'd14 - bit_r];
          end else begin
            mosi_s = mosi_r;
          end
        end else if (bit_r == 4'd15) begin
          state_s = ST_HOLD;
          cnt_s   = '0;
        end else begin
          cnt_s  = '0;
          bit_s  = bit_r + 4'd1;
          high_s = 1'b1;
          sclk_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_s     = ST_GAP;
          cnt_s       = '0;
          cs_n_s      = 1'b1;
          mosi_s      = 1'b0;
          rsp_valid_s = 1'b1;
          rdata_s     = shreg_r;
        end else begin
          cnt_s = cnt_r + ONE;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end else begin
          cnt_s = cnt_r + ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      bit_r       <= 4'd0;
      high_r      <= 1'b0;
      frame_r     <= 15'h0000;
      shreg_r     <= 8'h00;
      cs_n_r      <= 1'b1;
      sclk_r      <= 1'b0;
      mosi_r      <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= 8'h00;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_r       <= bit_s;
      high_r      <= high_s;
      frame_r     <= frame_s;
      shreg_r     <= shreg_s;
      cs_n_r      <= cs_n_s;
      sclk_r      <= sclk_s;
      mosi_r      <= mosi_s;
      ready_r     <= ready_s;
      busy_r      <= busy_s;
      rsp_valid_r <= rsp_valid_s;
      rdata_r     <= rdata_s;
    end
  end

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign spi_cs_n  = cs_n_r;
  assign spi_sclk  = sclk_r;
  assign spi_mosi  = mosi_r;

endmodule

// File: tb/tb_remap_spi_master.sv
// Scoreboard bench: dut0 uses default timing, dut1 the fastest legal timing.
// Stimulus pushes expected {frame, rdata}; a negedge monitor checks each response.
module tb_remap_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [1:0] cmd_valid, cmd_ready, cmd_rw, rsp_valid, busy, cs_n, sclk, mosi;
  logic [6:0] cmd_addr [2];
  logic [7:0] cmd_wdata [2];
  logic [7:0] rsp_rdata [2];
  logic       miso0, miso1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];
  logic [15:0] sl_q0[$];
  logic [15:0] sl_q1[$];

  remap_spi_master dut0 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_rw(cmd_rw[0]),
    .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso0)
  );

  remap_spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_rw(cmd_rw[1]),
    .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 'h%0h required 'h%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Mode-0 slaves: first bit valid when cs_n falls, next bit after each SCLK fall.
  logic [15:0] sw0, sw1;
  int          si0, si1;
  bit          sa0 = 1'b0, sa1 = 1'b0;

  always @(negedge cs_n[0] or posedge cs_n[0] or negedge sclk[0]) begin
    if (cs_n[0]) sa0 = 1'b0;
    else if (!sa0) begin
      sa0 = 1'b1;
      sw0 = (sl_q0.size() > 0) ? sl_q0.pop_front() : 16'h0000;
      si0 = 15;
      miso0 = sw0[15];
    end else if (!sclk[0]) begin
      if (si0 > 0) si0--;
      miso0 = sw0[si0];
    end
  end

  always @(negedge cs_n[1] or posedge cs_n[1] or negedge sclk[1]) begin
    if (cs_n[1]) sa1 = 1'b0;
    else if (!sa1) begin
      sa1 = 1'b1;
      sw1 = (sl_q1.size() > 0) ? sl_q1.pop_front() : 16'h0000;
      si1 = 15;
      miso1 = sw1[15];
    end else if (!sclk[1]) begin
      if (si1 > 0) si1--;
      miso1 = sw1[si1];
    end
  end

  // Monitor / scoreboard
  int          div_v [2] = '{4, 1};
  int          lat_v [2] = '{133, 35};
  int          gap_v [2] = '{2, 1};
  int          acc [2], rise [2], hi [2], cslow [2], first_low [2], hirun [2];
  logic [15:0] cap [2];
  logic [1:0]  prev_cs = 2'b11, prev_sclk = 2'b00, prev_rv = 2'b00;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        rise[i] = 0; hi[i] = 0; cslow[i] = 0; cap[i] = 16'h0000; hirun[i] = 0;
      end else begin
        logic [23:0] e;
        bit          have;
        if (cmd_valid[i] && cmd_ready[i]) acc[i] = cyc;
        if (prev_rv[i]) check_eq("rsp_valid_single_pulse", {31'd0, rsp_valid[i]}, 32'd0);
        if (cs_n[i]) hirun[i]++;
        else begin
          if (prev_cs[i]) begin
            first_low[i] = cyc;
            check_eq("cs_high_gap", {31'd0, (hirun[i] >= gap_v[i])}, 32'd1);
          end
          cslow[i]++;
          hirun[i] = 0;
        end
        if (sclk[i]) begin
          if (!prev_sclk[i]) begin
            rise[i]++;
            cap[i] = {cap[i][14:0], mosi[i]};
          end
          hi[i]++;
        end else if (hi[i] != 0) begin
          check_eq("sclk_high_width", hi[i], div_v[i]);
          hi[i] = 0;
        end
        if (rsp_valid[i]) begin
          have = 1'b0;
          e = 24'h0;
          if (i == 0 && exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
          if (i == 1 && exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
          check_eq("rsp_expected", {31'd0, have}, 32'd1);
          if (have) begin
            check_eq("rsp_rdata", {24'd0, rsp_rdata[i]}, {24'd0, e[7:0]});
            check_eq("mosi_frame", {16'd0, cap[i]}, {16'd0, e[23:8]});
            check_eq("sclk_rises", rise[i], 16);
            check_eq("rsp_latency", cyc - acc[i], lat_v[i]);
            check_eq("cs_low_cycles", cslow[i], lat_v[i] - 1);
            check_eq("cs_fall_cycle", first_low[i], acc[i] + 1);
            check_eq("cs_high_at_rsp", {31'd0, cs_n[i]}, 32'd1);
            check_eq("busy_at_rsp", {31'd0, busy[i]}, 32'd1);
          end
          rise[i] = 0; cap[i] = 16'h0000; cslow[i] = 0;
        end
      end
      prev_cs[i]   = cs_n[i];
      prev_sclk[i] = sclk[i];
      prev_rv[i]   = rsp_valid[i];
    end
  end

  task automatic send(input int i, input bit rw, input logic [6:0] a, input logic [7:0] wd,
                      input logic [15:0] slave_word, input logic [15:0] exp_frame,
                      input bit expect_rsp, input bit hold, output int acc_cyc);
    int n;
    @(posedge clk); #1;
    cmd_rw[i] = rw; cmd_addr[i] = a; cmd_wdata[i] = wd; cmd_valid[i] = 1'b1;
    if (i == 0) begin
      sl_q0.push_back(slave_word);
      if (expect_rsp) exp_q0.push_back({exp_frame, slave_word[7:0]});
    end else begin
      sl_q1.push_back(slave_word);
      if (expect_rsp) exp_q1.push_back({exp_frame, slave_word[7:0]});
    end
    n = 0;
    @(negedge clk);
    while (!cmd_ready[i] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_in_time", {31'd0, (n < 1000)}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    if (!hold) cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input logic [7:0] last_rdata);
    int n;
    n = 0;
    @(negedge clk);
    while (((i == 0 ? exp_q0.size() : exp_q1.size()) > 0 || !cmd_ready[i]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_in_time", {31'd0, (n < 2000)}, 32'd1);
    check_eq("busy_after_frame", {31'd0, busy[i]}, 32'd0);
    check_eq("rsp_rdata_held", {24'd0, rsp_rdata[i]}, {24'd0, last_rdata});
  endtask

  task automatic check_idle(input int i);
    check_eq("idle_cs_n", {31'd0, cs_n[i]}, 32'd1);
    check_eq("idle_sclk", {31'd0, sclk[i]}, 32'd0);
    check_eq("idle_mosi", {31'd0, mosi[i]}, 32'd0);
    check_eq("idle_cmd_ready", {31'd0, cmd_ready[i]}, 32'd1);
    check_eq("idle_busy", {31'd0, busy[i]}, 32'd0);
    check_eq("idle_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int a0, a1, n, r;
    bit ps;
    reset_n = 1'b1;
    cmd_valid = 2'b00; cmd_rw = 2'b00;
    cmd_addr[0] = 7'h00; cmd_addr[1] = 7'h00;
    cmd_wdata[0] = 8'h00; cmd_wdata[1] = 8'h00;
    miso0 = 1'b0; miso1 = 1'b0;

    // Reset asserted before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_idle(i);
      check_eq("reset_rdata", {24'd0, rsp_rdata[i]}, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_idle(i);

    // Write 0x2A <- 0xC3; slave returns 0x96 in the data phase.
    send(0, 1'b0, 7'h2A, 8'hC3, 16'h3C96, 16'h2AC3, 1'b1, 1'b0, a0);
    wait_done(0, 8'h96);

    // Read 0x05; header bits from the slave must be discarded.
    send(0, 1'b1, 7'h05, 8'h77, 16'hFFA5, 16'h8500, 1'b1, 1'b0, a0);
    wait_done(0, 8'hA5);

    // Back-to-back with cmd_valid held; fields change while frame one is in flight.
    send(0, 1'b0, 7'h11, 8'h5A, 16'h0033, 16'h115A, 1'b1, 1'b1, a0);
    send(0, 1'b1, 7'h40, 8'hFF, 16'h00C4, 16'hC000, 1'b1, 1'b0, a1);
    check_eq("back_to_back_accept", a1 - a0, 135);
    wait_done(0, 8'hC4);

    // Reset during bit 9 of SHIFT aborts the frame with no response.
    send(0, 1'b1, 7'h33, 8'h00, 16'h1234, 16'h0000, 1'b0, 1'b0, a0);
    n = 0; r = 0; ps = 1'b0;
    while (r < 10 && n < 2000) begin
      @(negedge clk);
      if (sclk[0] && !ps) r++;
      ps = sclk[0];
      n++;
    end
    check_eq("reach_bit9", r, 10);
    #2 reset_n = 1'b0;
    #1;
    check_idle(0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send(0, 1'b0, 7'h01, 8'h80, 16'h0077, 16'h0180, 1'b1, 1'b0, a0);
    wait_done(0, 8'h77);

    // Fastest timing: read 0x7F, slave data 0x01.
    send(1, 1'b1, 7'h7F, 8'h3C, 16'hAA01, 16'hFF00, 1'b1, 1'b0, a1);
    wait_done(1, 8'h01);

    repeat (5) @(negedge clk);
    check_eq("scoreboard0_empty", exp_q0.size(), 0);
    check_eq("scoreboard1_empty", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
